// File: rtl/pktd_fifo_ctrl.sv
// Packet-aware FIFO controller for the pktd data memory: commits whole frames from the host
// writer, rolls back aborted/oversize frames, and streams committed frames to the MAC tx path.
module pktd_fifo_ctrl #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 10,
  parameter int PKT_DEPTH = 16,
  parameter int MAX_LEN   = 384
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [DWIDTH-1:0]            wr_data,
  input  logic                         wr_last,
  input  logic                         wr_abort,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [DWIDTH-1:0]            rd_data,
  output logic                         rd_last,
  output logic [AWIDTH-1:0]            mem_waddr,
  output logic [DWIDTH-1:0]            mem_wdata,
  output logic                         mem_write,
  output logic [AWIDTH-1:0]            mem_raddr,
  input  logic [DWIDTH-1:0]            mem_rdata,
  output logic [$clog2(PKT_DEPTH):0]   pkt_cnt,
  output logic [15:0]                  drop_cnt
);
  localparam int DEPTH = 1 << AWIDTH;
  localparam int PW    = AWIDTH + 1;
  localparam int LW    = $clog2(MAX_LEN + 1);
  localparam int QW    = $clog2(PKT_DEPTH);
  localparam int CW    = QW + 1;

  typedef enum logic [1:0] {W_IDLE, W_WRITE, W_DROP} wstate_t;
  typedef enum logic {R_IDLE, R_STREAM} rstate_t;

  wstate_t wst, wst_nx;
  rstate_t rs, rs_nx;

  logic [PW-1:0] wr_ptr, cmt_ptr, rd_ptr, used;
  logic [LW-1:0] wcnt, wlen_nx, rcnt;
  logic [CW-1:0] lf_wp, lf_rp;
  logic [LW-1:0] len_mem [PKT_DEPTH];

  logic accept, in_frame, commit, abort_w, ovf, lf_empty, pop, rd_take, rd_done;

  assign used     = wr_ptr - rd_ptr;
  assign wlen_nx  = wcnt + LW'(1);
  assign accept   = wr_valid && wr_ready;
  assign in_frame = (wst != W_DROP);
  assign commit   = accept && in_frame && wr_last && !wr_abort;
  assign abort_w  = accept && in_frame && wr_abort;
  // Oversize: the beat that reaches MAX_LEN without last; a last on that beat still commits.
  assign ovf      = accept && in_frame && !wr_abort && !wr_last && (wlen_nx == LW'(MAX_LEN));

  always_comb begin
    wr_ready = 1'b0;
    if (!rst)
      wr_ready = (wst == W_DROP) ? 1'b1
               : (used != PW'(DEPTH)) && (pkt_cnt != CW'(PKT_DEPTH));
  end

  assign mem_write = accept && in_frame && !wr_abort;
  assign mem_waddr = wr_ptr[AWIDTH-1:0];
  assign mem_wdata = wr_data;

  // Only committed lengths are ever popped, so reads cannot overtake cmt_ptr.
  assign lf_empty  = (lf_wp == lf_rp);
  assign pop       = (rs == R_IDLE) && !lf_empty;
  assign rd_valid  = !rst && (rs == R_STREAM);
  assign rd_last   = rd_valid && (rcnt == LW'(1));
  assign rd_data   = mem_rdata;
  assign mem_raddr = rd_ptr[AWIDTH-1:0];
  assign rd_take   = rd_valid && rd_ready;
  assign rd_done   = rd_take && (rcnt == LW'(1));

  always_comb begin
    wst_nx = wst;
    case (wst)
      W_IDLE, W_WRITE:
        if (accept) begin
          if (wr_abort || wr_last) wst_nx = W_IDLE;
          else if (ovf)            wst_nx = W_DROP;
          else                     wst_nx = W_WRITE;
        end
      W_DROP:
        if (accept && (wr_last || wr_abort)) wst_nx = W_IDLE;
      default: wst_nx = W_IDLE;
    endcase
  end

  always_comb begin
    rs_nx = rs;
    case (rs)
      R_IDLE:   if (pop)     rs_nx = R_STREAM;
      R_STREAM: if (rd_done) rs_nx = R_IDLE;
      default:  rs_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit) len_mem[lf_wp[QW-1:0]] <= wlen_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wst      <= W_IDLE;
      rs       <= R_IDLE;
      wr_ptr   <= '0;
      cmt_ptr  <= '0;
      rd_ptr   <= '0;
      wcnt     <= '0;
      rcnt     <= '0;
      lf_wp    <= '0;
      lf_rp    <= '0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      wst <= wst_nx;
      rs  <= rs_nx;

      if (abort_w || ovf)  wr_ptr <= cmt_ptr;
      else if (mem_write)  wr_ptr <= wr_ptr + PW'(1);

      if (accept && in_frame) wcnt <= (abort_w || commit || ovf) ? '0 : wlen_nx;

      if (commit) begin
        cmt_ptr <= wr_ptr + PW'(1);
        lf_wp   <= lf_wp + CW'(1);
      end

      if ((abort_w || ovf) && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;

      if (pop) begin
        rcnt  <= len_mem[lf_rp[QW-1:0]];
        lf_rp <= lf_rp + CW'(1);
      end else if (rd_take) begin
        rcnt  <= rcnt - LW'(1);
      end
      if (rd_take) rd_ptr <= rd_ptr + PW'(1);

      // Commit and final read on the same edge cancel out.
      if (commit && !rd_done)      pkt_cnt <= pkt_cnt + CW'(1);
      else if (!commit && rd_done) pkt_cnt <= pkt_cnt - CW'(1);
    end
  end
endmodule
